mips32_mem_arbiter: RTL and testbench
=====================================

// Module: mips32_mem_arbiter
// PURPOSE
//   Shares the single-port 1024x32 instruction/data memory between the IF stage (read-only port "i")
//   and the MEM stage (load/store port "d"). Fixed priority to d, since MEM holds the older instruction.
//   A starvation limit forces an i grant after STARVE_LIMIT back-to-back d grants.
//   One transaction in flight; the FSM sequences issue, read-latency wait and acknowledge.
// PARAMETERS
//   ADDR_W        10  word-address width (1024 words)
//   DATA_W        32  data width
//   LATENCY        1  memory read latency in cycles, >=1 (rdata valid LATENCY cycles after mem_en)
//   STARVE_LIMIT   4  consecutive d grants, with i waiting, before i is forced; 0 = pure d priority
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       asynchronous reset, active-high
//   i_req      in   1       IF read request; held with i_addr until i_ack
//   i_addr     in   ADDR_W  IF word address
//   i_ack      out  1       one-cycle pulse: i_rdata valid
//   i_rdata    out  DATA_W  instruction word
//   d_req      in   1       MEM request; held with d_we/d_addr/d_wdata until d_ack
//   d_we       in   1       1 = store (SW), 0 = load (LW)
//   d_addr     in   ADDR_W  data word address
//   d_wdata    in   DATA_W  store data
//   d_ack      out  1       one-cycle pulse: store done / d_rdata valid
//   d_rdata    out  DATA_W  load data
//   mem_en     out  1       memory access strobe, one cycle per transaction
//   mem_we     out  1       memory write enable (only with mem_en)
//   mem_addr   out  ADDR_W  memory address
//   mem_wdata  out  DATA_W  memory write data
//   mem_rdata  in   DATA_W  memory read data
// BEHAVIOUR
//   - All outputs are registered. Reset: state=IDLE, streak=0; all acks, rdata, mem_* = 0.
//   - FSM: IDLE -> ISSUE -> (read: WAIT x LATENCY) -> RESP -> IDLE.
//     - IDLE: if any req is present, latch the winner (owner, we, addr, wdata) and go to ISSUE.
//     - ISSUE: mem_en=1 with owner's addr; mem_we=d_we when owner=d, else 0. Write -> RESP, read -> WAIT.
//     - WAIT: count LATENCY cycles; capture mem_rdata in the last WAIT cycle.
//     - RESP: owner's ack=1 and owner's rdata=captured word (rdata holds until next load); -> IDLE.
//   - Latency, req seen in IDLE at cycle 0: read ack at cycle LATENCY+2; write ack at cycle 2,
//     with the memory written at the end of cycle 1.
//   - Arbitration, sampled only in IDLE:
//     - Only one req present: that requester wins.
//     - Both present: d wins, unless STARVE_LIMIT!=0 and streak==STARVE_LIMIT; then i wins.
//   - streak (clog2(STARVE_LIMIT+1) bits, saturating):
//     - +1 on a d grant while i_req=1.
//     - Cleared on any i grant, and on a d grant while i_req=0.
//   - Requesters must drop or change req in the cycle after ack. RESP never grants, so the
//     stale req in RESP is ignored. Back-to-back transactions therefore need >=1 IDLE cycle.
//   - Request inputs are ignored outside IDLE. A req drop mid-transaction does not abort it;
//     the ack is still issued.
//   - Async reset mid-transaction: abort immediately, no ack, no further mem_en. A write already
//     strobed stays written. Requesters reissue after reset.
//   - Addresses pass through unmodified. No out-of-range checking (ADDR_W covers all memory).
// CONFIGURATION
//   MEM_ARB_PERF_CNT_EN defined:
//     - Adds outputs i_stall_cnt[31:0] and d_grant_cnt[31:0], both reset to 0 and wrapping modulo 2^32.
//     - i_stall_cnt +1 each cycle i_req=1 while owner!=i or state==IDLE-with-d-winning.
//     - d_grant_cnt +1 per d grant.
//   Not defined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//   1. Reset, i_req=1 i_addr=5, mem[5]=32'h2801000A, LATENCY=1:
//      mem_en at cycle 1 addr 5; i_ack at cycle 3 with i_rdata=32'h2801000A; d_ack stays 0.
//   2. d_req=1 d_we=1 d_addr=100 d_wdata=32'hDEADBEEF:
//      mem_en=mem_we=1 at cycle 1; d_ack at cycle 2. A follow-up load of 100 returns 32'hDEADBEEF.
//   3. i_req and d_req both held continuously, STARVE_LIMIT=4:
//      grant order d,d,d,d,i,d,d,d,d,i...; no requester is ever acked twice for one request.
//   4. Assert rst during WAIT of a read (LATENCY=3):
//      no ack appears; all outputs 0 asynchronously. The request reissued after reset completes normally.
//   5. LATENCY=3 read: mem_rdata is changed every cycle;
//      i_rdata equals the value present exactly 3 cycles after mem_en, ack at cycle 5.
//   6. With MEM_ARB_PERF_CNT_EN, scenario 3 run for 50 cycles: d_grant_cnt/i_stall_cnt match the model;
//      without the macro the bench compiles with those ports absent.

Source files
------------

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares one single-port instruction/data memory between the
// IF stage (read-only port i) and the MEM stage (load/store port d).
// Port d has fixed priority. A starvation limit forces an i grant after a run of
// d grants made while i was waiting. One transaction is in flight at a time.
// Optional macro MEM_ARB_PERF_CNT_EN adds the i_stall_cnt and d_grant_cnt counters.
module mips32_mem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_ARB_PERF_CNT_EN
    output logic [31:0]       i_stall_cnt,
    output logic [31:0]       d_grant_cnt,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]    WAIT_LAST  = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic                owner_d, owner_d_nxt;
    logic                op_we, op_we_nxt;
    logic [CNT_W-1:0]    wait_cnt, wait_cnt_nxt;
    logic [STREAK_W-1:0] streak, streak_nxt;
    logic                i_ack_nxt, d_ack_nxt;
    logic [DATA_W-1:0]   i_rdata_nxt, d_rdata_nxt;
    logic                mem_en_nxt, mem_we_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [DATA_W-1:0]   mem_wdata_nxt;
    logic                force_i, grant_d, grant_i;

    // Arbitration: d wins unless i has been starved for STARVE_LIMIT d grants.
    always_comb begin
        force_i = (STARVE_LIMIT != 0) && i_req && (streak == STREAK_MAX);
        grant_d = d_req && !force_i;
        grant_i = i_req && !grant_d;
    end

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_nxt     = state;
        owner_d_nxt   = owner_d;
        op_we_nxt     = op_we;
        wait_cnt_nxt  = wait_cnt;
        streak_nxt    = streak;
        i_ack_nxt     = 1'b0;
        d_ack_nxt     = 1'b0;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;
        case (state)
            IDLE: begin
                if (grant_d || grant_i) begin
                    state_nxt     = ISSUE;
                    owner_d_nxt   = grant_d;
                    op_we_nxt     = grant_d && d_we;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = grant_d && d_we;
                    mem_addr_nxt  = grant_d ? d_addr : i_addr;
                    mem_wdata_nxt = grant_d ? d_wdata : '0;
                    if (grant_d && i_req) begin
                        streak_nxt = (streak == STREAK_MAX) ? streak : streak + 1'b1;
                    end else begin
                        streak_nxt = '0;
                    end
                end
            end
            ISSUE: begin
                if (op_we) begin
                    state_nxt = RESP;
                    d_ack_nxt = owner_d;
                    i_ack_nxt = !owner_d;
                end else begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = RESP;
                    if (owner_d) begin
                        d_ack_nxt   = 1'b1;
                        d_rdata_nxt = mem_rdata;
                    end else begin
                        i_ack_nxt   = 1'b1;
                        i_rdata_nxt = mem_rdata;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, latched transaction and registered outputs; reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            op_we     <= 1'b0;
            wait_cnt  <= '0;
            streak    <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            owner_d   <= owner_d_nxt;
            op_we     <= op_we_nxt;
            wait_cnt  <= wait_cnt_nxt;
            streak    <= streak_nxt;
            i_ack     <= i_ack_nxt;
            d_ack     <= d_ack_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic i_stall;
    logic d_grant;

    // i stalls whenever it is requesting but d owns the memory or is winning IDLE.
    always_comb begin
        d_grant = (state == IDLE) && grant_d;
        i_stall = i_req && (d_grant || ((state != IDLE) && owner_d));
    end

    // Wrapping performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_stall_cnt <= '0;
            d_grant_cnt <= '0;
        end else begin
            if (i_stall) begin
                i_stall_cnt <= i_stall_cnt + 32'd1;
            end
            if (d_grant) begin
                d_grant_cnt <= d_grant_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Testbench for mips32_mem_arbiter with a behavioural memory, a reference memory
// image, and a transaction-level model of the grant order.
// Perf-counter checks are active when MEM_ARB_PERF_CNT_EN is defined.
module tb_mips32_mem_arbiter;

    localparam int LAT   = 3;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [9:0]  i_addr, d_addr;
    logic [31:0] d_wdata;
    logic        i_ack, d_ack;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] i_stall_cnt, d_grant_cnt;
`endif

    mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef MEM_ARB_PERF_CNT_EN
        .i_stall_cnt(i_stall_cnt), .d_grant_cnt(d_grant_cnt),
`endif
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pre_i = 0;
    int          ireq_cycles = 0;
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:127];
    logic [31:0] pipe [0:LAT-1];
    logic [31:0] hist [0:63];
    logic [31:0] ovr_val = 32'h0;
    logic        use_ovr = 1'b0;
    logic [31:0] last_d_load = 32'h0;

    int          en_cnt, en_cyc;
    logic [9:0]  en_addr;
    logic        en_we, ack_both;
    logic [31:0] en_wdata, ack_i_rdata, ack_d_rdata;

    function automatic logic [31:0] init_word(input int a);
        return (a == 5) ? 32'h2801000A : (32'hA5A5_0000 ^ 32'(a * 32'h0001_0F3D));
    endfunction

    // Cycle counter and count of clock edges that see i_req high.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (i_req) ireq_cycles <= ireq_cycles + 1;
    end

    // Synchronous memory: preload, writes, and LAT-stage read pipeline.
    always @(posedge clk) begin
        if (pre_i < 128) begin
            mem[10'(pre_i)] <= init_word(pre_i);
            pre_i <= pre_i + 1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 32'h0;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    // Free-running random read data, recorded per cycle, used when use_ovr is set.
    always @(negedge clk) begin
        ovr_val = $urandom;
        hist[6'(cyc % 64)] = ovr_val;
    end

    assign mem_rdata = use_ovr ? ovr_val : pipe[LAT-1];

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input bit is_d, input bit we, input logic [9:0] addr, input logic [31:0] wdata);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
    endtask

    task automatic wait_ack(output int who, output int ack_cyc);
        who = 0; ack_cyc = 0; en_cnt = 0; ack_both = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++; en_cyc = cyc; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
            end
            if (i_ack || d_ack) begin
                who = i_ack ? 1 : 2;
                ack_cyc = cyc;
                ack_both = i_ack && d_ack;
                ack_i_rdata = i_rdata;
                ack_d_rdata = d_rdata;
                break;
            end
        end
        total++;
        assert (who != 0) else begin
            bad++;
            $error("[TB] FAIL ack_timeout observed=no_ack expected=ack_within_40_cycles");
        end
    endtask

    task automatic single_txn(input bit is_d, input bit we, input logic [9:0] addr, input logic [31:0] wdata);
        int who, ack_cyc, c0;
        logic [31:0] exp_data;
        c0 = cyc;
        apply_stimulus(is_d, we, addr, wdata);
        wait_ack(who, ack_cyc);
        i_req = 1'b0; d_req = 1'b0;
        check_output("owner", 32'(who), is_d ? 32'd2 : 32'd1);
        check_output("one_ack", 32'(ack_both), 32'd0);
        check_output("en_count", 32'(en_cnt), 32'd1);
        check_output("en_cycle", 32'(en_cyc - c0), 32'd1);
        check_output("en_addr", 32'(en_addr), 32'(addr));
        check_output("en_we", 32'(en_we), 32'(is_d && we));
        if (is_d && we) begin
            check_output("st_wdata", en_wdata, wdata);
            check_output("st_latency", 32'(ack_cyc - c0), 32'd2);
            check_output("st_rdata_hold", ack_d_rdata, last_d_load);
            ref_mem[addr[6:0]] = wdata;
        end else begin
            exp_data = use_ovr ? hist[6'((c0 + 1 + LAT) % 64)] : ref_mem[addr[6:0]];
            check_output("rd_latency", 32'(ack_cyc - c0), 32'(LAT + 2));
            check_output("rd_data", is_d ? ack_d_rdata : ack_i_rdata, exp_data);
            if (is_d) last_d_load = exp_data;
        end
        @(negedge clk);
        check_output("ack_pulse", 32'({i_ack, d_ack}), 32'd0);
    endtask

    initial begin
        int who, ack_cyc, c0, quiet, k_streak, exp_who, n_i, n_d, last_ack, ireq0, exp_stall;
        bit last_was_i, cur_we;
        logic [9:0] cur_i_addr, cur_d_addr;
        logic [31:0] cur_wdata;
`ifdef MEM_ARB_PERF_CNT_EN
        logic [31:0] is0, dg0;
`endif
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < 128; k++) ref_mem[k] = init_word(k);
        repeat (140) @(negedge clk);

        // Reset state.
        check_output("rst_mem_en", 32'(mem_en), 32'd0);
        check_output("rst_acks", 32'({i_ack, d_ack}), 32'd0);
        check_output("rst_i_rdata", i_rdata, 32'd0);
        check_output("rst_d_rdata", d_rdata, 32'd0);
        check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Instruction fetch from word 5 and a store/load pair to word 100.
        single_txn(1'b0, 1'b0, 10'd5, 32'h0);
        single_txn(1'b1, 1'b1, 10'd100, 32'hDEADBEEF);
        single_txn(1'b1, 1'b0, 10'd100, 32'h0);
        check_output("t2_value", d_rdata, 32'hDEADBEEF);
        single_txn(1'b0, 1'b0, 10'd100, 32'h0);

        // Random single-requester traffic over a small address window.
        for (int t = 0; t < 20; t++) begin
            int kind;
            kind = $urandom_range(0, 2);
            single_txn(kind != 0, kind == 2, 10'($urandom_range(0, 127)), $urandom);
        end

        // Read data sampled exactly LAT cycles after mem_en while mem_rdata changes every cycle.
        use_ovr = 1'b1;
        single_txn(1'b0, 1'b0, 10'd9, 32'h0);
        single_txn(1'b1, 1'b0, 10'd10, 32'h0);
        use_ovr = 1'b0;

        // Asynchronous reset while a read is in its wait phase.
        c0 = cyc;
        apply_stimulus(1'b0, 1'b0, 10'd7, 32'h0);
        @(negedge clk);
        check_output("r4_issue", 32'(mem_en), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_output("r4_acks", 32'({i_ack, d_ack}), 32'd0);
        check_output("r4_mem_en", 32'(mem_en), 32'd0);
        check_output("r4_i_rdata", i_rdata, 32'd0);
        check_output("r4_d_rdata", d_rdata, 32'd0);
        i_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_d_load = 32'h0;
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_en || i_ack || d_ack) quiet++;
        end
        check_output("r4_quiet", 32'(quiet), 32'd0);
        single_txn(1'b0, 1'b0, 10'd7, 32'h0);

        // Both requesters held continuously: grant order follows the starvation rule.
        k_streak = 0; n_i = 0; n_d = 0; last_ack = cyc - 10; last_was_i = 1'b0;
        cur_i_addr = 10'($urandom_range(0, 127));
        cur_d_addr = 10'($urandom_range(0, 127));
        cur_we = 1'($urandom_range(0, 1));
        cur_wdata = $urandom;
        ireq0 = ireq_cycles;
`ifdef MEM_ARB_PERF_CNT_EN
        is0 = i_stall_cnt;
        dg0 = d_grant_cnt;
`endif
        apply_stimulus(1'b0, 1'b0, cur_i_addr, 32'h0);
        apply_stimulus(1'b1, cur_we, cur_d_addr, cur_wdata);
        for (int g = 0; g < 15; g++) begin
            exp_who = (k_streak == LIMIT) ? 1 : 2;
            wait_ack(who, ack_cyc);
            check_output("arb_order", 32'(who), 32'(exp_who));
            check_output("arb_gap", 32'(ack_cyc - last_ack >= 3), 32'd1);
            check_output("arb_en_count", 32'(en_cnt), 32'd1);
            last_ack = ack_cyc;
            if (exp_who == 2) begin
                if (cur_we) begin
                    ref_mem[cur_d_addr[6:0]] = cur_wdata;
                end else begin
                    check_output("arb_d_data", ack_d_rdata, ref_mem[cur_d_addr[6:0]]);
                end
                cur_d_addr = 10'($urandom_range(0, 127));
                cur_we = 1'($urandom_range(0, 1));
                cur_wdata = $urandom;
                apply_stimulus(1'b1, cur_we, cur_d_addr, cur_wdata);
                k_streak++; n_d++; last_was_i = 1'b0;
            end else begin
                check_output("arb_i_data", ack_i_rdata, ref_mem[cur_i_addr[6:0]]);
                cur_i_addr = 10'($urandom_range(0, 127));
                apply_stimulus(1'b0, 1'b0, cur_i_addr, 32'h0);
                k_streak = 0; n_i++; last_was_i = 1'b1;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        exp_stall = (ireq_cycles - ireq0) - n_i * (LAT + 3) + (last_was_i ? 1 : 0);
`ifdef MEM_ARB_PERF_CNT_EN
        check_output("perf_d_grant", d_grant_cnt - dg0, 32'(n_d));
        check_output("perf_i_stall", i_stall_cnt - is0, 32'(exp_stall));
`endif
        $display("[TB] contention run: d grants=%0d i grants=%0d model i stall=%0d", n_d, n_i, exp_stall);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
